gnt_lock: RTL



---
 rtl/gnt_lock.sv | 139 +++++++++++++
 1 files changed

// File: rtl/gnt_lock.sv
// Grant lock: binds each grant slot to its output lane until end of packet and exports held inputs as a busy mask.
// Optional idle-lane forced release is built when GNT_LOCK_TIMEOUT_EN is defined.
module gnt_lock #(
    parameter int WIDTH_N     = 10,
    parameter int AMOUNT_M    = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [AMOUNT_M-1:0][WIDTH_N-1:0]   gnt_i,
    input  logic                               gnt_vld_i,
    output logic                               gnt_rdy_o,
    input  logic [AMOUNT_M-1:0]                lane_last_i,
    input  logic [AMOUNT_M-1:0]                lane_beat_i,
    output logic [AMOUNT_M-1:0][WIDTH_N-1:0]   sel_o,
    output logic [AMOUNT_M-1:0]                lane_busy_o,
    output logic [WIDTH_N-1:0]                 busy_o,
    output logic [AMOUNT_M-1:0]                timeout_o
);

    typedef enum logic {EMPTY = 1'b0, PEND = 1'b1} pend_state_t;

    pend_state_t pend_state, pend_state_nx;
    logic                             pend_vld, rdy_q, capture, dispatch;
    logic [AMOUNT_M-1:0][WIDTH_N-1:0] pend_gnt, sel_q, sel_nx;
    logic [AMOUNT_M-1:0]              busy_q, busy_nx, needed, blocked, rel_last, expire;
    logic [WIDTH_N-1:0]               held;

    assign pend_vld = (pend_state == PEND);
    assign capture  = gnt_vld_i & rdy_q;

    always_comb begin
        held = '0;
        for (int m = 0; m < AMOUNT_M; m++) begin
            if (busy_q[m]) held |= sel_q[m];
        end
    end

    // Dispatch looks only at registered lane state, so a lane freed at this edge is usable one edge later.
    always_comb begin
        needed   = '0;
        blocked  = '0;
        rel_last = '0;
        for (int m = 0; m < AMOUNT_M; m++) begin
            needed[m]   = |pend_gnt[m];
            blocked[m]  = needed[m] & (busy_q[m] | (|(pend_gnt[m] & held)));
            rel_last[m] = busy_q[m] & lane_last_i[m];
        end
        dispatch = pend_vld & ~(|blocked);
    end

    always_comb begin
        pend_state_nx = pend_state;
        case (pend_state)
            EMPTY: if (capture)  pend_state_nx = PEND;
            PEND:  if (dispatch) pend_state_nx = EMPTY;
        endcase
    end

`ifdef GNT_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [AMOUNT_M-1:0][CNT_W-1:0] cnt_q, cnt_nx;
    logic [AMOUNT_M-1:0]            tmo_q;

    // End of packet wins over timeout, so an expiring lane that also sees its last beat reports no timeout.
    always_comb begin
        expire = '0;
        cnt_nx = cnt_q;
        for (int m = 0; m < AMOUNT_M; m++) begin
            expire[m] = busy_q[m] & ~lane_last_i[m] & (cnt_q[m] == CNT_W'(TIMEOUT_CYC));
            if (!busy_q[m] || rel_last[m] || expire[m] || lane_beat_i[m])
                cnt_nx[m] = '0;
            else
                cnt_nx[m] = cnt_q[m] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tmo_q <= '0;
        end else begin
            cnt_q <= cnt_nx;
            tmo_q <= expire;
        end
    end

    assign timeout_o = tmo_q;
`else
    logic unused_cfg;

    assign expire     = '0;
    assign timeout_o  = '0;
    assign unused_cfg = ^lane_beat_i ^ (TIMEOUT_CYC > 0);
`endif

    always_comb begin
        sel_nx  = sel_q;
        busy_nx = busy_q;
        for (int m = 0; m < AMOUNT_M; m++) begin
            if (rel_last[m] | expire[m]) begin
                busy_nx[m] = 1'b0;
                sel_nx[m]  = '0;
            end else if (dispatch & needed[m]) begin
                busy_nx[m] = 1'b1;
                sel_nx[m]  = pend_gnt[m];
            end
        end
    end

    // Ready is registered; it stays low through reset and rises on the first edge afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_state <= EMPTY;
            pend_gnt   <= '0;
            rdy_q      <= 1'b0;
            sel_q      <= '0;
            busy_q     <= '0;
        end else begin
            pend_state <= pend_state_nx;
            rdy_q      <= (pend_state_nx == EMPTY);
            sel_q      <= sel_nx;
            busy_q     <= busy_nx;
            if (capture) pend_gnt <= gnt_i;
        end
    end

    assign gnt_rdy_o   = rdy_q;
    assign sel_o       = sel_q;
    assign lane_busy_o = busy_q;
    assign busy_o      = held;

    for (genvar m = 0; m < AMOUNT_M; m++) begin : g_onehot
        a_onehot: assert property (@(posedge clk) disable iff (reset)
            capture |-> $onehot0(gnt_i[m]));
    end

endmodule
